eth_idma_reg_sequencer: RTL and testbench

- Register-bus initiator that programs and launches single 1D transfers on the Ethernet iDMA register block.
- Accepts a transfer descriptor over a valid/ready port, then issues the register writes that set up the transfer.
- Polls the iDMA request-ready and response-valid bits, completes the response handshake, and reports a completion status.
- Sits between a host-side control engine (e.g. a packet-descriptor ring walker) and the Ethernet iDMA configuration bus.

---
 rtl/eth_idma_reg_sequencer_if.sv | 40 ++++
 rtl/eth_idma_reg_sequencer.sv | 156 +++++++++++++++
 tb/tb_eth_idma_reg_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_idma_reg_sequencer_if.sv
// rtl/eth_idma_reg_sequencer_if.sv - descriptor, register-bus and completion signals of the iDMA register sequencer
interface eth_idma_reg_sequencer_if #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned AW_REGBUS  = 8
);
    logic                  desc_valid_i;
    logic                  desc_ready_o;
    logic [AddrWidth-1:0]  desc_src_addr_i;
    logic [AddrWidth-1:0]  desc_dst_addr_i;
    logic [TFLenWidth-1:0] desc_length_i;
    logic [2:0]            desc_src_prot_i;
    logic [2:0]            desc_dst_prot_i;
    logic [AW_REGBUS-1:0]  reg_addr_o;
    logic                  reg_write_o;
    logic [31:0]           reg_wdata_o;
    logic [3:0]            reg_wstrb_o;
    logic                  reg_valid_o;
    logic [31:0]           reg_rdata_i;
    logic                  reg_error_i;
    logic                  reg_ready_i;
    logic                  done_valid_o;
    logic [1:0]            done_status_o;
    logic                  busy_o;

    // master: the sequencer itself (initiator of register accesses)
    modport master (
        input  desc_valid_i, desc_src_addr_i, desc_dst_addr_i, desc_length_i,
               desc_src_prot_i, desc_dst_prot_i, reg_rdata_i, reg_error_i, reg_ready_i,
        output desc_ready_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
               reg_valid_o, done_valid_o, done_status_o, busy_o
    );

    modport slave (
        output desc_valid_i, desc_src_addr_i, desc_dst_addr_i, desc_length_i,
               desc_src_prot_i, desc_dst_prot_i, reg_rdata_i, reg_error_i, reg_ready_i,
        input  desc_ready_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
               reg_valid_o, done_valid_o, done_status_o, busy_o
    );
endinterface

// File: rtl/eth_idma_reg_sequencer.sv
// rtl/eth_idma_reg_sequencer.sv - programs, launches and completes one 1D iDMA transfer over the register bus
module eth_idma_reg_sequencer #(
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          TFLenWidth  = 32,
    parameter int unsigned          AW_REGBUS   = 8,
    parameter logic [AW_REGBUS-1:0] SrcAddrOff  = 8'h00,
    parameter logic [AW_REGBUS-1:0] DstAddrOff  = 8'h04,
    parameter logic [AW_REGBUS-1:0] LengthOff   = 8'h08,
    parameter logic [AW_REGBUS-1:0] SrcProtOff  = 8'h0C,
    parameter logic [AW_REGBUS-1:0] DstProtOff  = 8'h10,
    parameter logic [AW_REGBUS-1:0] ReqValidOff = 8'h14,
    parameter logic [AW_REGBUS-1:0] ReqReadyOff = 8'h18,
    parameter logic [AW_REGBUS-1:0] RspValidOff = 8'h1C,
    parameter logic [AW_REGBUS-1:0] RspReadyOff = 8'h20,
    parameter int unsigned          PollTimeout = 1024
) (
    input logic                       clk_i,
    input logic                       rst_i,
    eth_idma_reg_sequencer_if.master  bus
);
    localparam int unsigned     CntW   = $clog2(PollTimeout + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(PollTimeout);

    typedef enum logic [3:0] {
        IDLE, W_SRC, W_DST, W_LEN, W_SPROT, W_DPROT, W_REQV1, P_REQRDY,
        W_REQV0, P_RSPV, W_RSPR1, W_RSPR0, ABORT, DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 gap_q, gap_d;
    logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [1:0]           status_q, status_d;
    logic [31:0]          src_q, dst_q, len_q;
    logic [2:0]           sprot_q, dprot_q;
    logic                 accept, access, is_write, valid, complete;
    logic [AW_REGBUS-1:0] addr;
    logic [31:0]          wdata;
    logic                 unused_rdata;

    assign unused_rdata = ^bus.reg_rdata_i[31:1];
    assign accept       = (state_q == IDLE) && bus.desc_valid_i;
    assign cnt_inc      = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gap_q    <= 1'b0;
            cnt_q    <= '0;
            status_q <= 2'd0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            sprot_q  <= '0;
            dprot_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            if (accept) begin
                src_q   <= 32'(bus.desc_src_addr_i);
                dst_q   <= 32'(bus.desc_dst_addr_i);
                len_q   <= 32'(bus.desc_length_i);
                sprot_q <= bus.desc_src_prot_i;
                dprot_q <= bus.desc_dst_prot_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = 1'b0;
        cnt_d    = cnt_q;
        status_d = status_q;
        access   = 1'b1;
        is_write = 1'b1;
        addr     = '0;
        wdata    = '0;
        unique case (state_q)
            IDLE: begin
                access   = 1'b0;
                is_write = 1'b0;
                if (accept) begin
                    state_d  = W_SRC;
                    status_d = 2'd0;
                end
            end
            W_SRC:    begin addr = SrcAddrOff;  wdata = src_q;             end
            W_DST:    begin addr = DstAddrOff;  wdata = dst_q;             end
            W_LEN:    begin addr = LengthOff;   wdata = len_q;             end
            W_SPROT:  begin addr = SrcProtOff;  wdata = {29'd0, sprot_q};  end
            W_DPROT:  begin addr = DstProtOff;  wdata = {29'd0, dprot_q};  end
            W_REQV1:  begin addr = ReqValidOff; wdata = 32'd1;             end
            P_REQRDY: begin addr = ReqReadyOff; is_write = 1'b0;           end
            W_REQV0:  begin addr = ReqValidOff;                            end
            P_RSPV:   begin addr = RspValidOff; is_write = 1'b0;           end
            W_RSPR1:  begin addr = RspReadyOff; wdata = 32'd1;             end
            W_RSPR0:  begin addr = RspReadyOff;                            end
            ABORT:    begin addr = ReqValidOff;                            end
            DONE: begin
                access   = 1'b0;
                is_write = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                access   = 1'b0;
                is_write = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // gap_q forces one idle bus cycle after every completed access
        valid    = access && !gap_q;
        complete = valid && bus.reg_ready_i;
        if (complete) begin
            gap_d = 1'b1;
            if (bus.reg_error_i && state_q != ABORT) begin
                state_d  = ABORT;
                status_d = 2'd1;
            end else begin
                unique case (state_q)
                    W_SRC:   state_d = W_DST;
                    W_DST:   state_d = W_LEN;
                    W_LEN:   state_d = W_SPROT;
                    W_SPROT: state_d = W_DPROT;
                    W_DPROT: state_d = W_REQV1;
                    W_REQV1: begin state_d = P_REQRDY; cnt_d = '0; end
                    W_REQV0: begin state_d = P_RSPV;   cnt_d = '0; end
                    P_REQRDY, P_RSPV: begin
                        cnt_d = cnt_inc;
                        if (bus.reg_rdata_i[0]) begin
                            state_d = (state_q == P_REQRDY) ? W_REQV0 : W_RSPR1;
                        end else if (cnt_inc == CntMax) begin
                            state_d  = ABORT;
                            status_d = 2'd2;
                        end
                    end
                    W_RSPR1: state_d = W_RSPR0;
                    W_RSPR0: state_d = DONE;
                    ABORT:   state_d = DONE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign bus.desc_ready_o  = (state_q == IDLE) && !rst_i;
    assign bus.reg_valid_o   = valid;
    assign bus.reg_write_o   = valid && is_write;
    assign bus.reg_addr_o    = valid ? addr : '0;
    assign bus.reg_wdata_o   = (valid && is_write) ? wdata : 32'd0;
    assign bus.reg_wstrb_o   = (valid && is_write) ? 4'hF : 4'h0;
    assign bus.done_valid_o  = (state_q == DONE);
    assign bus.done_status_o = (state_q == DONE) ? status_q : 2'd0;
    assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_eth_idma_reg_sequencer.sv
// tb/tb_eth_idma_reg_sequencer.sv - scoreboard bench for eth_idma_reg_sequencer
module tb_eth_idma_reg_sequencer;
    localparam int PT = 6;
    localparam logic [2:0] AXI = 3'd0, OBI = 3'd1, AXIS = 3'd2;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_idma_reg_sequencer_if #(.AddrWidth(32), .TFLenWidth(32), .AW_REGBUS(8)) bus ();
    eth_idma_reg_sequencer #(.PollTimeout(PT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.master));

    acc_t       exp_q[$];
    logic [1:0] exp_done_q[$];
    int checks = 0, errors = 0, done_cnt = 0;

    // responder knobs
    int         delay = 0;
    int         reqrdy_zeros = 0;
    bit         rspv_never = 0;
    bit         stall_reqrdy = 0;
    logic [7:0] err_addr = 8'hFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // register-bus slave model
    initial begin
        int   waitcnt;
        logic [44:0] held;
        waitcnt = 0;
        held = '0;
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;
        bus.reg_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            bus.reg_ready_i = 1'b0;
            bus.reg_error_i = 1'b0;
            bus.reg_rdata_i = 32'd0;
            if (bus.reg_valid_o && !rst) begin
                if (waitcnt == 0)
                    held = {bus.reg_write_o, bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o};
                else
                    check("hold_stable", {19'd0, bus.reg_write_o, bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o}, {19'd0, held});
                if (waitcnt >= delay && !(stall_reqrdy && bus.reg_addr_o == 8'h18)) begin
                    bus.reg_ready_i = 1'b1;
                    waitcnt = 0;
                    if (!bus.reg_write_o && bus.reg_addr_o == 8'h18) begin
                        if (reqrdy_zeros > 0) begin
                            reqrdy_zeros--;
                            bus.reg_rdata_i = 32'hFFFF_FFFE;
                        end else begin
                            bus.reg_rdata_i = 32'h0000_0001;
                        end
                    end
                    if (!bus.reg_write_o && bus.reg_addr_o == 8'h1C)
                        bus.reg_rdata_i = rspv_never ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
                    if (bus.reg_write_o && bus.reg_addr_o == err_addr)
                        bus.reg_error_i = 1'b1;
                end else begin
                    waitcnt++;
                end
            end else begin
                waitcnt = 0;
            end
        end
    end

    // monitor: pops the scoreboard on every completed access and every done pulse
    initial begin
        acc_t       e;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.reg_valid_o && bus.reg_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("unexpected_access addr=%0h wr=%0b", bus.reg_addr_o, bus.reg_write_o));
                end else begin
                    e = exp_q.pop_front();
                    check("access_kind_addr", {55'd0, bus.reg_write_o, bus.reg_addr_o}, {55'd0, e.wr, e.addr});
                    if (e.wr) check("access_wdata", {32'd0, bus.reg_wdata_o}, {32'd0, e.data});
                    check("access_wstrb", {60'd0, bus.reg_wstrb_o}, {60'd0, (e.wr ? 4'hF : 4'h0)});
                end
            end
            if (!rst && bus.done_valid_o) begin
                done_cnt++;
                check("busy_during_done", {63'd0, bus.busy_o}, 64'd1);
                if (exp_done_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    s = exp_done_q.pop_front();
                    check("done_status", {62'd0, bus.done_status_o}, {62'd0, s});
                end
            end
        end
    end

    task automatic push(input logic wr, input logic [7:0] a, input logic [31:0] d);
        acc_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_setup(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                              input logic [2:0] sp, input logic [2:0] dp);
        push(1, 8'h00, s);
        push(1, 8'h04, d);
        push(1, 8'h08, l);
        push(1, 8'h0C, {29'd0, sp});
        push(1, 8'h10, {29'd0, dp});
        push(1, 8'h14, 32'd1);
    endtask

    task automatic push_tail();
        push(1, 8'h14, 32'd0);
        push(0, 8'h1C, 32'd0);
        push(1, 8'h20, 32'd1);
        push(1, 8'h20, 32'd0);
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic [2:0] sp, input logic [2:0] dp);
        int n;
        @(negedge clk);
        bus.desc_src_addr_i = s;
        bus.desc_dst_addr_i = d;
        bus.desc_length_i   = l;
        bus.desc_src_prot_i = sp;
        bus.desc_dst_prot_i = dp;
        bus.desc_valid_i    = 1'b1;
        n = 0;
        while (!bus.desc_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.desc_ready_o) fail("desc_accept_timeout");
        @(posedge clk);
        @(negedge clk);
        bus.desc_valid_i = 1'b0;
        bus.desc_src_addr_i = 32'hDEAD_BEEF;
        check("busy_after_accept", {63'd0, bus.busy_o}, 64'd1);
        check("desc_ready_while_busy", {63'd0, bus.desc_ready_o}, 64'd0);
    endtask

    task automatic wait_idle(input string name, input int start_done);
        int n;
        n = 0;
        while (bus.busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy_o) fail({name, "_busy_timeout"});
        #2;
        check({name, "_queue_drained"}, exp_q.size(), 64'd0);
        check({name, "_done_count"}, done_cnt - start_done, 64'd1);
        check({name, "_ready_idle"}, {63'd0, bus.desc_ready_o}, 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outputs"},
              {19'd0, bus.desc_ready_o, bus.reg_valid_o, bus.reg_write_o, bus.reg_addr_o,
               bus.reg_wdata_o, bus.reg_wstrb_o, bus.done_valid_o, bus.done_status_o, bus.busy_o},
              64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks + 1, errors + 1);
        $fatal(1);
    end

    initial begin
        int d0;
        bus.desc_valid_i    = 1'b0;
        bus.desc_src_addr_i = '0;
        bus.desc_dst_addr_i = '0;
        bus.desc_length_i   = '0;
        bus.desc_src_prot_i = '0;
        bus.desc_dst_prot_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("ready_after_reset", {63'd0, bus.desc_ready_o}, 64'd1);

        // basic transfer, immediate bus, first polls succeed
        d0 = done_cnt;
        push_setup(32'h8000_0000, 32'h0, 32'd64, AXI, AXIS);
        push(0, 8'h18, 32'd0);
        push_tail();
        exp_done_q.push_back(2'd0);
        send(32'h8000_0000, 32'h0, 32'd64, AXI, AXIS);
        wait_idle("basic", d0);

        // slow bus: 3 wait cycles per access
        delay = 3;
        d0 = done_cnt;
        push_setup(32'h1234_5678, 32'h9ABC_DEF0, 32'd1500, OBI, AXI);
        push(0, 8'h18, 32'd0);
        push_tail();
        exp_done_q.push_back(2'd0);
        send(32'h1234_5678, 32'h9ABC_DEF0, 32'd1500, OBI, AXI);
        wait_idle("slow_bus", d0);
        delay = 0;

        // REQ_READY low for five polls
        reqrdy_zeros = 5;
        d0 = done_cnt;
        push_setup(32'h0000_1000, 32'h0000_2000, 32'd4, AXIS, AXIS);
        for (int i = 0; i < 6; i++) push(0, 8'h18, 32'd0);
        push_tail();
        exp_done_q.push_back(2'd0);
        send(32'h0000_1000, 32'h0000_2000, 32'd4, AXIS, AXIS);
        wait_idle("reqrdy_poll", d0);

        // RSP_VALID never set: timeout after PT reads, counter restarted after REQRDY polls
        reqrdy_zeros = 3;
        rspv_never = 1'b1;
        d0 = done_cnt;
        push_setup(32'hCAFE_0000, 32'h0BAD_F00D, 32'd256, AXI, AXI);
        for (int i = 0; i < 4; i++) push(0, 8'h18, 32'd0);
        push(1, 8'h14, 32'd0);
        for (int i = 0; i < PT; i++) push(0, 8'h1C, 32'd0);
        push(1, 8'h14, 32'd0);
        exp_done_q.push_back(2'd2);
        send(32'hCAFE_0000, 32'h0BAD_F00D, 32'd256, AXI, AXI);
        wait_idle("timeout", d0);
        rspv_never = 1'b0;

        // bus error on LENGTH write
        err_addr = 8'h08;
        d0 = done_cnt;
        push(1, 8'h00, 32'h0000_00AA);
        push(1, 8'h04, 32'h0000_00BB);
        push(1, 8'h08, 32'd8);
        push(1, 8'h14, 32'd0);
        exp_done_q.push_back(2'd1);
        send(32'h0000_00AA, 32'h0000_00BB, 32'd8, AXI, OBI);
        wait_idle("bus_error", d0);
        err_addr = 8'hFF;

        // reset while a REQ_READY read is outstanding
        stall_reqrdy = 1'b1;
        push_setup(32'h5555_0000, 32'hAAAA_0000, 32'd32, AXI, AXIS);
        send(32'h5555_0000, 32'hAAAA_0000, 32'd32, AXI, AXIS);
        begin
            int n;
            n = 0;
            while (!(bus.reg_valid_o && !bus.reg_write_o && bus.reg_addr_o == 8'h18) && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) fail("reach_reqrdy_timeout");
        end
        #2;
        check("reset_test_queue", exp_q.size(), 64'd0);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        #1;
        check_all_zero("mid_reset_held");
        rst = 1'b0;
        stall_reqrdy = 1'b0;
        #1;
        check("ready_after_mid_reset", {63'd0, bus.desc_ready_o}, 64'd1);
        d0 = done_cnt;
        push_setup(32'h0000_0040, 32'h0000_0080, 32'd128, OBI, OBI);
        push(0, 8'h18, 32'd0);
        push_tail();
        exp_done_q.push_back(2'd0);
        send(32'h0000_0040, 32'h0000_0080, 32'd128, OBI, OBI);
        wait_idle("after_reset", d0);

        repeat (3) @(negedge clk);
        check("no_stray_done", exp_done_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
